// File: rtl/rc4_stream_ctrl.sv
// RC4 sequencer: owns the S-box and runs identity fill, key scheduling and
// byte-paced keystream generation behind a valid/ready stream.
module rc4_stream_ctrl #(
    parameter int KEY_BYTES = 16,
    parameter int LEN_W     = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [LEN_W-1:0]       key_len,
    output logic                   busy,
    output logic                   key_ready,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    input  logic                   out_ready
);

    typedef enum logic [3:0] {
        IDLE, FILL, KSA_J, KSA_SWAP, READY, PRG_I, PRG_J, PRG_SWAP, PRG_OUT, HOLD
    } state_t;

    state_t state, state_nx;

    logic [7:0]             sbox [256];
    logic [7:0]             i, j, k, len_m1, byte_r;
    logic [8*KEY_BYTES-1:0] key_r;
    logic [7:0]             key_byte, s_i, s_j, s_t, t_idx;
    logic [LEN_W-1:0]       len_eff;

    assign s_i   = sbox[i];
    assign s_j   = sbox[j];
    assign t_idx = s_i + s_j;
    assign s_t   = sbox[t_idx];

    // Out-of-range lengths fall back to the full key
    assign len_eff = (key_len == '0 || key_len > LEN_W'(KEY_BYTES)) ? LEN_W'(KEY_BYTES) : key_len;

    always_comb begin
        key_byte = '0;
        for (int b = 0; b < KEY_BYTES; b++)
            if (k == 8'(b)) key_byte = key_r[8*b +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        key_ready = 1'b0;
        case (state)
            IDLE:     if (start) state_nx = FILL;
            FILL: begin
                busy = 1'b1;
                if (i == 8'd255) state_nx = KSA_J;
            end
            KSA_J: begin
                busy     = 1'b1;
                state_nx = KSA_SWAP;
            end
            KSA_SWAP: begin
                busy     = 1'b1;
                state_nx = (i == 8'd255) ? READY : KSA_J;
            end
            READY: begin
                key_ready = 1'b1;
                if (start)         state_nx = FILL;
                else if (in_valid) state_nx = PRG_I;
            end
            PRG_I:    state_nx = PRG_J;
            PRG_J:    state_nx = PRG_SWAP;
            PRG_SWAP: state_nx = PRG_OUT;
            PRG_OUT:  state_nx = HOLD;
            HOLD:     if (out_ready) state_nx = READY;
            default:  state_nx = IDLE;
        endcase
    end

    assign in_ready = key_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i         <= '0;
            j         <= '0;
            k         <= '0;
            len_m1    <= '0;
            byte_r    <= '0;
            key_r     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE, READY: begin
                    if (start) begin
                        key_r  <= key;
                        len_m1 <= 8'(len_eff) - 8'd1;
                        i      <= '0;
                        j      <= '0;
                        k      <= '0;
                    end else if (state == READY && in_valid) begin
                        byte_r <= in_data;
                    end
                end
                FILL:     i <= i + 8'd1;
                KSA_J:    j <= j + s_i + key_byte;
                KSA_SWAP: begin
                    i <= i + 8'd1;
                    k <= (k == len_m1) ? 8'd0 : k + 8'd1;
                    if (i == 8'd255) j <= '0;
                end
                PRG_I:    i <= i + 8'd1;
                PRG_J:    j <= j + s_i;
                PRG_OUT: begin
                    out_data  <= byte_r ^ s_t;
                    out_valid <= 1'b1;
                end
                HOLD:     if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    // S-box contents are don't-care after reset, so no reset term here
    always_ff @(posedge clk) begin
        case (state)
            FILL: sbox[i] <= i;
            KSA_SWAP, PRG_SWAP: begin
                sbox[i] <= s_j;
                sbox[j] <= s_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rc4_stream_ctrl.sv
// Self-checking bench for rc4_stream_ctrl against a plain-arithmetic RC4 model.
module tb_rc4_stream_ctrl;
    localparam int KB = 16;

    logic          clk = 0, reset = 0, start = 0;
    logic [8*KB-1:0] key = '0;
    logic [4:0]    key_len = '0;
    logic          busy, key_ready, in_ready, out_valid;
    logic          in_valid = 0, out_ready = 0;
    logic [7:0]    in_data = 0, out_data;

    int errors = 0, checks = 0;
    int ms[256];
    int mi, mj;

    always #5 clk = ~clk;

    rc4_stream_ctrl #(.KEY_BYTES(KB), .LEN_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .key(key), .key_len(key_len),
        .busy(busy), .key_ready(key_ready),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic model_key(input logic [127:0] kk, input int len);
        int L, jj, t;
        L  = (len == 0 || len > KB) ? KB : len;
        jj = 0;
        for (int n = 0; n < 256; n++) ms[n] = n;
        for (int n = 0; n < 256; n++) begin
            jj = (jj + ms[n] + int'(kk[8*(n % L) +: 8])) % 256;
            t = ms[n]; ms[n] = ms[jj]; ms[jj] = t;
        end
        mi = 0;
        mj = 0;
    endtask

    function automatic int ks();
        int t;
        mi = (mi + 1) % 256;
        mj = (mj + ms[mi]) % 256;
        t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
        return ms[(ms[mi] + ms[mj]) % 256];
    endfunction

    task automatic pack(input string s, output logic [127:0] kk);
        kk = '0;
        for (int b = 0; b < s.len(); b++) kk[8*b +: 8] = s[b];
    endtask

    task automatic rand_key(output logic [127:0] kk);
        for (int b = 0; b < KB; b++) kk[8*b +: 8] = 8'($urandom);
    endtask

    // Entered on a negedge; returns on the negedge after keying completes.
    task automatic do_key(input logic [127:0] kk, input int len, input bit spam);
        int bad;
        bad = 0;
        key = kk; key_len = 5'(len); start = 1;
        @(negedge clk);
        start = 0;
        for (int c = 0; c < 768; c++) begin
            if (!(busy === 1'b1 && key_ready === 1'b0 && in_ready === 1'b0)) bad++;
            start = spam && (c % 97 == 5);
            @(negedge clk);
        end
        start = 0;
        chk("busy_window", 64'(bad), 0);
        chk("key_ready_768", key_ready, 1);
        chk("busy_off_768", busy, 0);
        model_key(kk, len);
    endtask

    // Entered on a negedge in READY; returns on the negedge after out_valid drops.
    task automatic send_byte(input logic [7:0] d, input bit bp, input bit spam, output logic [7:0] got);
        int lat, bad, cyc;
        logic [7:0] exp_v, held;
        chk("in_ready_pre", in_ready, 1);
        in_valid = 1; in_data = d;
        @(negedge clk);
        in_valid = 0; in_data = 8'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("byte_latency", 64'(lat), 4);
        exp_v = d ^ 8'(ks());
        got   = out_data;
        chk("out_data", out_data, exp_v);
        held = out_data;
        bad = 0; cyc = 0;
        do begin
            out_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
            start = spam && (cyc == 0);
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || busy !== 1'b0) bad++;
            @(negedge clk);
            start = 0;
            cyc++;
        end while (out_ready == 1'b0 && cyc < 200);
        out_ready = 0;
        chk("hold_stable", 64'(bad), 0);
        chk("out_valid_drop", out_valid, 0);
        chk("ready_again", in_ready, 1);
    endtask

    logic [7:0] exp_key [9]  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] exp_wiki [5] = '{8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    logic [7:0] exp_sec [14] = '{8'h45, 8'hA0, 8'h1F, 8'h64, 8'h5F, 8'hC3, 8'h5B,
                                 8'h38, 8'h35, 8'h52, 8'h54, 8'h4B, 8'h9B, 8'hF5};

    initial begin
        logic [127:0] kk;
        logic [7:0]   g, ks0;
        logic [7:0]   ct [5];
        logic [7:0]   ref16 [6];
        logic [7:0]   dat16 [6];
        string        pt;
        int           c;

        #1 reset = 1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_key_ready", key_ready, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        repeat (3) @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);
        chk("idle_key_ready", key_ready, 0);
        chk("idle_busy", busy, 0);

        // "Key" / "Plaintext"
        pack("Key", kk);
        do_key(kk, 3, 0);
        pt = "Plaintext";
        for (int b = 0; b < 9; b++) begin
            send_byte(pt[b], 0, 0, g);
            chk("vec_key", g, exp_key[b]);
        end

        // "Wiki" / "pedia", with ignored starts during keying, then decrypt
        pack("Wiki", kk);
        do_key(kk, 4, 1);
        pt = "pedia";
        for (int b = 0; b < 5; b++) begin
            send_byte(pt[b], 0, 0, g);
            ct[b] = g;
            chk("vec_wiki", g, exp_wiki[b]);
        end
        do_key(kk, 4, 0);
        for (int b = 0; b < 5; b++) begin
            send_byte(ct[b], 0, 0, g);
            chk("wiki_decrypt", g, 8'(pt[b]));
        end

        // "Secret" with backpressure and ignored starts during HOLD
        pack("Secret", kk);
        do_key(kk, 6, 0);
        pt = "Attack at dawn";
        for (int b = 0; b < 14; b++) begin
            send_byte(pt[b], 1, (b % 3 == 0), g);
            chk("vec_secret", g, exp_sec[b]);
        end

        // Rekey from READY after two bytes; start beats a simultaneous in_valid
        pack("Rekey", kk);
        do_key(kk, 5, 0);
        send_byte(8'h5A, 0, 0, g);
        ks0 = g ^ 8'h5A;
        send_byte(8'h33, 0, 0, g);
        key = kk; key_len = 5; start = 1; in_valid = 1; in_data = 8'hEE;
        @(negedge clk);
        start = 0; in_valid = 0;
        chk("rekey_busy", busy, 1);
        chk("rekey_key_ready", key_ready, 0);
        c = 0;
        while (key_ready !== 1'b1 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        chk("rekey_latency", 64'(c), 768);
        model_key(kk, 5);
        send_byte(8'h77, 0, 0, g);
        chk("rekey_ks0", g ^ 8'h77, ks0);

        // key_len 0 and >KEY_BYTES behave as full length
        rand_key(kk);
        for (int b = 0; b < 6; b++) dat16[b] = 8'($urandom);
        do_key(kk, 16, 0);
        for (int b = 0; b < 6; b++) send_byte(dat16[b], 0, 0, ref16[b]);
        do_key(kk, 0, 0);
        for (int b = 0; b < 6; b++) begin
            send_byte(dat16[b], 0, 0, g);
            chk("len0_eq_len16", g, ref16[b]);
        end
        do_key(kk, $urandom_range(17, 31), 0);
        for (int b = 0; b < 6; b++) begin
            send_byte(dat16[b], 1, 0, g);
            chk("lenbig_eq_len16", g, ref16[b]);
        end

        // Random keys, lengths, data and backpressure
        for (int r = 0; r < 3; r++) begin
            rand_key(kk);
            do_key(kk, $urandom_range(1, 16), 0);
            for (int b = 0; b < 8; b++) send_byte(8'($urandom), 1'($urandom), 0, g);
        end

        // Asynchronous reset mid-cycle while an output is pending
        in_valid = 1; in_data = 8'hC3;
        @(negedge clk);
        in_valid = 0;
        c = 0;
        while (out_valid !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("pre_reset_valid", out_valid, 1);
        #2 reset = 1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_key_ready", key_ready, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        reset = 0;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", key_ready, 0);
        rand_key(kk);
        do_key(kk, $urandom_range(1, 16), 0);
        for (int b = 0; b < 3; b++) send_byte(8'($urandom), 0, 0, g);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
